// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared types and defaults for the tick scheduler.
// Channel state enum, default parameters and the configuration request struct.
package tick_sched_pkg;

  // Channel state: IDLE ignores base ticks, RUN counts them.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  localparam int DEF_PRESCALE = 100;
  localparam int DEF_NCH      = 4;
  localparam int DEF_PW       = 16;

  // The request struct is sized for the widest supported build:
  // up to 256 channels and 32-bit periods. Narrower builds zero-extend.
  localparam int CFG_CH_W     = 8;
  localparam int CFG_PERIOD_W = 32;

  typedef struct packed {
    logic [CFG_CH_W-1:0]     ch;
    logic                    start;
    logic [CFG_PERIOD_W-1:0] period;
    logic                    oneshot;
  } cfg_req_t;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_sched_channel.sv
// tick_sched_channel: one scheduler channel (IDLE/RUN FSM, base-tick counter,
// registered ch_tick). Oneshot support is built only when
// TICK_SCHED_ONESHOT_EN is defined; otherwise every channel is periodic.
module tick_sched_channel
  import tick_sched_pkg::*;
#(
  parameter int PW = DEF_PW
) (
  input  logic          clk,
  input  logic          reset_p,
  input  logic          base_tick,
  input  logic          load,
  input  logic          run,
  input  logic [PW-1:0] period,
  input  logic          oneshot,
  output logic          ch_tick,
  output logic          ch_active
);

  ch_state_t     state_reg, state_next;
  logic [PW-1:0] cnt_reg, cnt_next;
  logic [PW-1:0] period_reg, period_next;
  logic          tick_next;
  logic          fire_once;

`ifdef TICK_SCHED_ONESHOT_EN
  logic oneshot_reg, oneshot_next;

  assign fire_once = oneshot_reg;

  // Oneshot flag latched with the period on every start.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) oneshot_reg <= 1'b0;
    else         oneshot_reg <= oneshot_next;
  end
`else
  logic unused_oneshot;

  assign fire_once      = 1'b0;
  assign unused_oneshot = oneshot;
`endif

  // State, counter, period and tick registers.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      period_reg <= '0;
      ch_tick    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      period_reg <= period_next;
      ch_tick    <= tick_next;
    end
  end

  // Next state: a configuration load wins over a coincident base tick.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    period_next = period_reg;
    tick_next   = 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
    oneshot_next = oneshot_reg;
`endif
    if (load) begin
      if (run) begin
        state_next  = RUN;
        cnt_next    = period;
        period_next = period;
`ifdef TICK_SCHED_ONESHOT_EN
        oneshot_next = oneshot;
`endif
      end else begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    end else if (state_reg == RUN && base_tick) begin
      if (cnt_reg > PW'(1)) begin
        cnt_next = cnt_reg - PW'(1);
      end else begin
        tick_next = 1'b1;
        if (fire_once) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = period_reg;
        end
      end
    end
  end

  assign ch_active = (state_reg == RUN);

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler plus NCH run-time configurable event channels.
// Optional feature macro: TICK_SCHED_ONESHOT_EN (per-channel fire-once mode).
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int NCH      = DEF_NCH,
  parameter int PW       = DEF_PW
) (
  input  logic                     clk,
  input  logic                     reset_p,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ch_idx_w(NCH)-1:0] cfg_ch,
  input  logic                     cfg_start,
  input  logic [PW-1:0]            cfg_period,
  input  logic                     cfg_oneshot,
  output logic                     base_tick,
  output logic [NCH-1:0]           ch_tick,
  output logic [NCH-1:0]           ch_active
);

  localparam int PSW = $clog2(PRESCALE);

  logic [PSW-1:0] presc_cnt;
  logic           xfer;
  logic           start_ok;
  cfg_req_t       cfg_req;

  assign xfer     = cfg_valid && cfg_ready;
  assign cfg_req  = '{ch:      CFG_CH_W'(cfg_ch),
                      start:   cfg_start,
                      period:  CFG_PERIOD_W'(cfg_period),
                      oneshot: cfg_oneshot};
  // A zero period is treated as a stop request.
  assign start_ok = cfg_req.start && (cfg_req.period != '0);

  // Prescaler: base_tick is registered on the edge the counter wraps to 0.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      presc_cnt <= '0;
      base_tick <= 1'b0;
    end else if (presc_cnt == PSW'(PRESCALE - 1)) begin
      presc_cnt <= '0;
      base_tick <= 1'b1;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
      base_tick <= 1'b0;
    end
  end

  // Handshake: ready after reset, then low for one apply cycle per transfer.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) cfg_ready <= 1'b0;
    else         cfg_ready <= !xfer;
  end

  // Channel decode: indices with no matching channel are accepted and dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      tick_sched_channel #(
        .PW(PW)
      ) u_ch (
        .clk      (clk),
        .reset_p  (reset_p),
        .base_tick(base_tick),
        .load     (xfer && (cfg_req.ch == CFG_CH_W'(gi))),
        .run      (start_ok),
        .period   (cfg_req.period[PW-1:0]),
        .oneshot  (cfg_req.oneshot),
        .ch_tick  (ch_tick[gi]),
        .ch_active(ch_active[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed scenarios plus random configuration traffic,
// checked every cycle against a cycle-number based model of the scheduler.
module tb_tick_scheduler;

  localparam int P   = 4;
  localparam int NCH = 4;
  localparam int PW  = 8;
`ifdef TICK_SCHED_ONESHOT_EN
  localparam bit ONESHOT_EN = 1'b1;
`else
  localparam bit ONESHOT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_p = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic           cfg_start = 1'b0;
  logic [PW-1:0]  cfg_period = '0;
  logic           cfg_oneshot = 1'b0;
  logic           base_tick;
  logic [NCH-1:0] ch_tick;
  logic [NCH-1:0] ch_active;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit done     = 1'b0;

  // Model: cyc = number of clock edges since reset release; cycle n is the
  // interval following edge n. Each channel remembers the cycle its next
  // ch_tick is due.
  int           cyc = 0;
  bit           m_ready = 1'b0;
  bit [NCH-1:0] m_tick = '0;
  bit           m_act[NCH];
  bit           m_os[NCH];
  int           m_per[NCH];
  int           m_next[NCH];

  tick_scheduler #(
    .PRESCALE(P),
    .NCH     (NCH),
    .PW      (PW)
  ) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_start  (cfg_start),
    .cfg_period (cfg_period),
    .cfg_oneshot(cfg_oneshot),
    .base_tick  (base_tick),
    .ch_tick    (ch_tick),
    .ch_active  (ch_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
  endtask

  // Model update on each clock edge (or reset).
  initial begin
    forever begin
      @(posedge clk or posedge reset_p);
      if (reset_p) begin
        cyc     = 0;
        m_ready = 1'b0;
        m_tick  = '0;
        for (int k = 0; k < NCH; k++) m_act[k] = 1'b0;
      end else begin
        bit xfer;
        int k;
        int first_bt;
        cyc++;
        xfer    = cfg_valid && m_ready;
        m_ready = !xfer;
        m_tick  = '0;
        if (xfer) begin
          k = int'(cfg_ch);
          if (k < NCH) begin
            if (cfg_start && cfg_period != 0) begin
              // base ticks counted are those high in cycles >= cyc
              first_bt  = ((cyc + P - 1) / P) * P;
              m_act[k]  = 1'b1;
              m_per[k]  = int'(cfg_period);
              m_os[k]   = ONESHOT_EN && cfg_oneshot;
              m_next[k] = first_bt + P * (m_per[k] - 1) + 1;
            end else begin
              m_act[k] = 1'b0;
            end
          end
        end
        for (int c = 0; c < NCH; c++) begin
          if (m_act[c] && cyc == m_next[c]) begin
            m_tick[c] = 1'b1;
            if (m_os[c]) m_act[c] = 1'b0;
            else         m_next[c] += P * m_per[c];
          end
        end
      end
    end
  end

  // Compare DUT against model in the middle of every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        logic [NCH-1:0] exp_act;
        for (int k = 0; k < NCH; k++) exp_act[k] = m_act[k];
        check("base_tick", 32'(base_tick), 32'(cyc > 0 && cyc % P == 0));
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        check("ch_tick",   32'(ch_tick),   32'(m_tick));
        check("ch_active", 32'(ch_active), 32'(exp_act));
      end
    end
  end

  // Present a request at a negedge and wait for its transfer edge; returns
  // at the following negedge with cfg_valid still high.
  task automatic send(input int ch, input bit st, input int per, input bit os);
    bit r;
    int tries;
    cfg_valid   = 1'b1;
    cfg_ch      = 2'(ch);
    cfg_start   = st;
    cfg_period  = PW'(per);
    cfg_oneshot = os;
    tries       = 0;
    do begin
      r = cfg_ready;
      @(posedge clk);
      if (!r) begin
        @(negedge clk);
        tries++;
      end
    end while (!r && tries < 10);
    if (!r) begin
      chk_cnt++;
      $display("FAIL send_timeout cyc=%0d got=ready_low exp=accept", cyc);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    int t1, t2, ticks;
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    @(negedge clk);
    // cycle 1
    check("ready_cycle1", 32'(cfg_ready), 32'd1);
    check("no_bt_cycle1", 32'(base_tick), 32'd0);

    send(0, 1'b1, 3, 1'b0);            // transfer at edge 2
    check("ch0_active_c2", 32'(ch_active[0]), 32'd1);
    send(1, 1'b1, 2, 1'b1);            // transfer at edge 4
    idle();
    check("first_bt_c4", 32'(base_tick), 32'd1);

    wait_cyc(9);
    check("ch1_tick_c9", 32'(ch_tick[1]), 32'd1);
    check("ch1_active_c9", 32'(ch_active[1]), 32'(!ONESHOT_EN));
    wait_cyc(13);
    check("ch0_tick_c13", 32'(ch_tick[0]), 32'd1);

    wait_cyc(16);
    send(2, 1'b1, 5, 1'b0);            // transfer at edge 17, colliding with base tick
    idle();
    wait_cyc(25);
    check("ch0_tick_c25", 32'(ch_tick[0]), 32'd1);
    wait_cyc(33);
    check("ch2_no_tick_c33", 32'(ch_tick[2]), 32'd0);
    wait_cyc(37);
    check("ch2_tick_c37", 32'(ch_tick[2]), 32'd1);
    check("ch0_tick_c37", 32'(ch_tick[0]), 32'd1);

    wait_cyc(40);
    send(0, 1'b0, 0, 1'b0);            // stop ch0 at edge 41
    t1 = cyc;
    check("ch0_idle_c41", 32'(ch_active[0]), 32'd0);
    check("ready_apply_c41", 32'(cfg_ready), 32'd0);
    send(3, 1'b1, 1, 1'b0);            // held valid: accepted at edge 43
    t2 = cyc;
    idle();
    check("b2b_spacing", 32'(t2 - t1), 32'd2);
    wait_cyc(45);
    check("ch3_tick_c45", 32'(ch_tick[3]), 32'd1);
    wait_cyc(49);
    check("ch3_tick_c49", 32'(ch_tick[3]), 32'd1);
    check("ch0_stopped_c49", 32'(ch_tick[0]), 32'd0);

    wait_cyc(58);
    #1 reset_p = 1'b1;
    #1;
    check("rst_base_tick", 32'(base_tick), 32'd0);
    check("rst_ch_tick",   32'(ch_tick),   32'd0);
    check("rst_ch_active", 32'(ch_active), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
    ticks = 0;
    repeat (30) begin
      @(negedge clk);
      if (|ch_tick) ticks++;
    end
    check("no_tick_after_rst", 32'(ticks), 32'd0);
    check("idle_after_rst", 32'(ch_active), 32'd0);

    // Random configuration traffic.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      send(int'($urandom_range(0, NCH - 1)), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    repeat (40) @(negedge clk);
    done = 1'b1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
